// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: rx FSM states and
// sampling constants.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  // Tick index inside the start bit where the line is re-checked (bit centre).
  function automatic int mid_sample(input int os);
    return os / 2 - 1;
  endfunction

  localparam int MID_SAMPLE = mid_sample(OVERSAMPLE_DEF);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with a
// configurable reset value so idle-high lines do not fake an edge.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  // Capture then re-register to let metastability settle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver. The baud clock is treated as a plain
// input: it is synchronized and edge-detected into a one-clk tick.
// Optional even-parity bit enabled with macro UART_RX_PARITY_EN.
// DATA_BITS must be at least 2.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_baud_clk,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] MID  = CW'(mid_sample(OVERSAMPLE));
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic rxd_s, baud_s, baud_q, tick, deliver;

  rx_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bits_q, bits_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  brk_q, brk_d;
  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                  par_bad_q, par_bad_d;
  logic                  parity_err_q, parity_err_d;
`endif

  sync2 #(.RST_VAL(1'b1)) u_sync_rxd  (.clk(clk), .reset(reset), .d_i(rxd),         .q_o(rxd_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_baud (.clk(clk), .reset(reset), .d_i(rx_baud_clk), .q_o(baud_s));

  assign tick = baud_s & ~baud_q;

  // State register plus all output/holding registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_q      <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bits_q      <= '0;
      shift_q     <= '0;
      brk_q       <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      baud_q      <= baud_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bits_q      <= bits_d;
      shift_q     <= shift_d;
      brk_q       <= brk_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next state: frame sequencing on tick, then delivery/handshake every clk.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bits_d      = bits_q;
    shift_d     = shift_q;
    brk_d       = brk_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == MID) begin
            // A line that is high again at mid-bit was only a glitch.
            cnt_d   = '0;
            bits_d  = '0;
            state_d = rxd_s ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            if (bits_q == LAST_BIT) begin
              bits_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bits_d = bits_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == LAST) begin
            cnt_d     = '0;
            par_bad_d = ^{shift_q, rxd_s};
            state_d   = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (brk_q) begin
            // Break: wait for the line to return high before re-arming.
            if (rxd_s) begin
              brk_d   = 1'b0;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else if (cnt_q == LAST) begin
            cnt_d = '0;
            if (rxd_s) begin
              deliver = 1'b1;
              state_d = IDLE;
            end else begin
              frame_err_d = 1'b1;
              brk_d       = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (deliver) begin
      if (rx_valid_q && !rx_ack) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      parity_err_d = par_bad_q;
`endif
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx. The bench generates the baud clock itself
// so every sample tick, and the stop-sample tick in particular, is known.
module tb_uart_rx;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_baud_clk = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, parity_err;

  int   tests = 0;
  int   fails = 0;
  int   fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  logic pre_v, post_v;

  uart_rx #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE)) dut (
    .clk(clk), .reset(reset), .rx_baud_clk(rx_baud_clk), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_err)  fe_cnt++;
    if (overrun)    ov_cnt++;
    if (parity_err) pe_cnt++;
  end

  // One sample tick (5 clks). Starts and ends on a negedge. ack is held
  // for exactly the clk in which the DUT acts on this tick.
  task automatic do_tick(input logic ack);
    rx_baud_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rx_ack = ack;
    @(negedge clk);
    rx_baud_clk = 1'b0;
    rx_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) do_tick(1'b0);
  endtask

  task automatic ack_once();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
  endtask

  // Start, LSB-first data, optional parity, stop. Tick 9 of each bit is
  // the DUT's sample point; rx_valid is captured around the stop sample.
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic par_b, input logic ack_stop);
    logic [10:0] bits;
    int nb;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (PAR_EN) begin
      bits[9] = par_b; bits[10] = stop_b; nb = 11;
    end else begin
      bits[9] = stop_b; nb = 10;
    end
    for (int b = 0; b < nb; b++) begin
      rxd = bits[b];
      for (int t = 1; t <= OVERSAMPLE; t++) begin
        if (b == nb - 1 && t == 9) begin
          pre_v = rx_valid;
          do_tick(ack_stop);
          post_v = rx_valid;
        end else begin
          do_tick(1'b0);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", rx_data); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    tests++; if (parity_err !== 1'b0) begin fails++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
    reset = 1'b0;
    idle(4);
  endtask

  task automatic test_basic();
    int fe0 = fe_cnt, ov0 = ov_cnt, pe0 = pe_cnt;
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    idle(4);
    tests++; if (pre_v !== 1'b0) begin fails++; $display("FAIL basic_valid_before_stop: got %b want 0", pre_v); end
    tests++; if (post_v !== 1'b1) begin fails++; $display("FAIL basic_valid_after_stop: got %b want 1", post_v); end
    tests++; if (rx_data !== 8'h55) begin fails++; $display("FAIL basic_data: got %h want 55", rx_data); end
    tests++; if (fe_cnt - fe0 + ov_cnt - ov0 + pe_cnt - pe0 !== 0) begin fails++; $display("FAIL basic_err_pulses: got %0d want 0", fe_cnt - fe0 + ov_cnt - ov0 + pe_cnt - pe0); end
    ack_once();
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL basic_ack_clears: got %b want 0", rx_valid); end
  endtask

  task automatic test_glitch();
    int fe0 = fe_cnt, ov0 = ov_cnt, pe0 = pe_cnt;
    rxd = 1'b0;
    repeat (3) do_tick(1'b0);
    idle(30);
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
    tests++; if (fe_cnt - fe0 + ov_cnt - ov0 + pe_cnt - pe0 !== 0) begin fails++; $display("FAIL glitch_err_pulses: got %0d want 0", fe_cnt - fe0 + ov_cnt - ov0 + pe_cnt - pe0); end
  endtask

  task automatic test_frame_err();
    int fe0 = fe_cnt;
    send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
    idle(20);
    tests++; if (fe_cnt - fe0 !== 1) begin fails++; $display("FAIL frame_err_count: got %0d want 1", fe_cnt - fe0); end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL frame_err_valid: got %b want 0", rx_valid); end
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    idle(4);
    tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL after_ferr_valid: got %b want 1", rx_valid); end
    tests++; if (rx_data !== 8'h3C) begin fails++; $display("FAIL after_ferr_data: got %h want 3c", rx_data); end
    tests++; if (fe_cnt - fe0 !== 1) begin fails++; $display("FAIL after_ferr_count: got %0d want 1", fe_cnt - fe0); end
    ack_once();
  endtask

  task automatic test_back_to_back();
    int ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    idle(6);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    idle(6);
    tests++; if (ov_cnt - ov0 !== 1) begin fails++; $display("FAIL overrun_count: got %0d want 1", ov_cnt - ov0); end
    tests++; if (rx_data !== 8'h11) begin fails++; $display("FAIL overrun_keeps_old: got %h want 11", rx_data); end
    tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL overrun_valid: got %b want 1", rx_valid); end
    ov0 = ov_cnt;
    send_frame(8'h22, 1'b1, 1'b0, 1'b1);
    idle(6);
    tests++; if (rx_data !== 8'h22) begin fails++; $display("FAIL ack_coincident_data: got %h want 22", rx_data); end
    tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL ack_coincident_valid: got %b want 1", rx_valid); end
    tests++; if (ov_cnt - ov0 !== 0) begin fails++; $display("FAIL ack_coincident_overrun: got %0d want 0", ov_cnt - ov0); end
    ack_once();
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL b2b_ack_clears: got %b want 0", rx_valid); end
  endtask

  task automatic test_reset_mid();
    int fe0 = fe_cnt, ov0 = ov_cnt, pe0 = pe_cnt;
    // Start bit plus four '1' data bits of 0xFF, then reset.
    rxd = 1'b0;
    repeat (OVERSAMPLE) do_tick(1'b0);
    rxd = 1'b1;
    repeat (4 * OVERSAMPLE) do_tick(1'b0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL midrst_data: got %h want 00", rx_data); end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", rx_valid); end
    tests++; if ({frame_err, overrun, parity_err} !== 3'b000) begin fails++; $display("FAIL midrst_pulses: got %b want 000", {frame_err, overrun, parity_err}); end
    reset = 1'b0;
    @(negedge clk);
    idle(60);
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL midrst_no_delivery: got %b want 0", rx_valid); end
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    idle(4);
    tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL midrst_next_valid: got %b want 1", rx_valid); end
    tests++; if (rx_data !== 8'h81) begin fails++; $display("FAIL midrst_next_data: got %h want 81", rx_data); end
    tests++; if (fe_cnt - fe0 + ov_cnt - ov0 + pe_cnt - pe0 !== 0) begin fails++; $display("FAIL midrst_err_pulses: got %0d want 0", fe_cnt - fe0 + ov_cnt - ov0 + pe_cnt - pe0); end
    ack_once();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int pe0 = pe_cnt;
    // 0x07 has three ones, so even parity needs a 1; send 0 instead.
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    idle(4);
    tests++; if (rx_data !== 8'h07) begin fails++; $display("FAIL parity_data: got %h want 07", rx_data); end
    tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL parity_valid: got %b want 1", rx_valid); end
    tests++; if (pe_cnt - pe0 !== 1) begin fails++; $display("FAIL parity_err_count: got %0d want 1", pe_cnt - pe0); end
    ack_once();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
